// File: rtl/smg_pkg.sv
// Shared definitions for the scanned 7-segment display bus: segment patterns,
// scan codes and the capture FSM state type.
package smg_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SMG_0 = 7'b1000000;
  localparam logic [6:0] SMG_1 = 7'b1111001;
  localparam logic [6:0] SMG_2 = 7'b0100100;
  localparam logic [6:0] SMG_3 = 7'b0110000;
  localparam logic [6:0] SMG_4 = 7'b0011001;
  localparam logic [6:0] SMG_5 = 7'b0010010;
  localparam logic [6:0] SMG_6 = 7'b0000010;
  localparam logic [6:0] SMG_7 = 7'b1111000;
  localparam logic [6:0] SMG_8 = 7'b0000000;
  localparam logic [6:0] SMG_9 = 7'b0010000;
  localparam logic [6:0] SMG_A = 7'b0001000;
  localparam logic [6:0] SMG_B = 7'b0000011;
  localparam logic [6:0] SMG_C = 7'b1000110;
  localparam logic [6:0] SMG_D = 7'b0100001;
  localparam logic [6:0] SMG_E = 7'b0000110;
  localparam logic [6:0] SMG_F = 7'b0001110;

  // Table indexed by nibble value; entry 0 sits in the low bits
  localparam logic [15:0][6:0] SMG_TABLE = {
    SMG_F, SMG_E, SMG_D, SMG_C, SMG_B, SMG_A, SMG_9, SMG_8,
    SMG_7, SMG_6, SMG_5, SMG_4, SMG_3, SMG_2, SMG_1, SMG_0
  };

  // One-cold digit select codes
  localparam logic [3:0] SCAN_D0 = 4'b1110;
  localparam logic [3:0] SCAN_D1 = 4'b1101;
  localparam logic [3:0] SCAN_D2 = 4'b1011;
  localparam logic [3:0] SCAN_D3 = 4'b0111;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } smg_state_e;

  // Returns {valid, digit index}; anything but the four one-cold codes is invalid
  function automatic logic [2:0] scan_decode(input logic [3:0] scan);
    case (scan)
      SCAN_D0: scan_decode = 3'b1_00;
      SCAN_D1: scan_decode = 3'b1_01;
      SCAN_D2: scan_decode = 3'b1_10;
      SCAN_D3: scan_decode = 3'b1_11;
      default: scan_decode = 3'b0_00;
    endcase
  endfunction

endpackage

// File: rtl/smg_decode_module.sv
// Segment pattern -> hex nibble. Reverse lookup over the shared table so the
// encoder side and this decoder can never disagree.
module smg_decode_module
  import smg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_valid,
  output logic [3:0] o_nibble
);

  // Linear search of the 16 patterns; no match means undecodable
  always_comb begin
    o_valid  = 1'b0;
    o_nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == SMG_TABLE[i]) begin
        o_valid  = 1'b1;
        o_nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/smg_capture_module.sv
// Receive side of the 4-digit scanned 7-segment bus: synchronise, wait for each
// digit to settle, decode it and reassemble 16-bit frames.
module smg_capture_module
  import smg_pkg::*;
#(
  parameter logic [15:0] SETTLE_CYC  = 16'd255,
  parameter logic [23:0] TIMEOUT_CYC = 24'd249999
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [6:0]  SMG_Data,
  input  logic [3:0]  Scan_Sig,
  output logic [15:0] Number_Sig,
  output logic        Number_Valid,
  output logic        Frame_Err,
  output logic        Scan_Lost
);

  logic [10:0]      r_sync1, r_sync2;
  logic [3:0]       w_scan;
  logic [6:0]       w_seg;
  logic             w_scan_vld;
  logic [2:0]       w_scan_dec;

  smg_state_e       r_state, w_state_nxt;
  logic [3:0]       r_lat_scan;
  logic [6:0]       r_lat_seg;
  logic [15:0]      r_settle_cnt;
  logic             w_lat_ld, w_cnt_inc, w_cap;

  logic [2:0]       w_lat_dec;
  logic [1:0]       w_cap_idx;
  logic [3:0]       w_cap_bit;
  logic             w_dig_vld;
  logic [3:0]       w_dig_nib;

  logic [3:0][3:0]  r_slot;
  logic [3:0]       r_seen;
  logic             r_err;
  logic             w_complete;

  logic [23:0]      r_tmo_cnt;
  logic             w_tmo_hit;

  // Two-flop synchroniser; idles at all-ones (blank segments, no digit selected)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= {Scan_Sig, SMG_Data};
      r_sync2 <= r_sync1;
    end
  end

  assign w_scan     = r_sync2[10:7];
  assign w_seg      = r_sync2[6:0];
  assign w_scan_dec = scan_decode(w_scan);
  assign w_scan_vld = w_scan_dec[2];

  // Next-state: a digit must hold scan+segments unchanged SETTLE_CYC cycles
  always_comb begin
    w_state_nxt = r_state;
    w_lat_ld    = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (w_scan_vld) begin
          w_state_nxt = S_SETTLE;
          w_lat_ld    = 1'b1;
        end
      end
      S_SETTLE: begin
        if (!w_scan_vld) begin
          w_state_nxt = S_WAIT;
        end else if ({w_scan, w_seg} != {r_lat_scan, r_lat_seg}) begin
          w_lat_ld = 1'b1;
        end else if (r_settle_cnt == SETTLE_CYC - 16'd1) begin
          w_cap       = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_HOLD: begin
        // Segment changes within a held digit are ignored; only a new scan phase counts
        if (w_scan != r_lat_scan) begin
          if (w_scan_vld) begin
            w_state_nxt = S_SETTLE;
            w_lat_ld    = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // State register, latched bus snapshot and settle counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_WAIT;
      r_lat_scan   <= '1;
      r_lat_seg    <= '1;
      r_settle_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_lat_ld) begin
        r_lat_scan   <= w_scan;
        r_lat_seg    <= w_seg;
        r_settle_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_settle_cnt <= r_settle_cnt + 16'd1;
      end
    end
  end

  // Decode the latched snapshot; it equals the live bus whenever w_cap is high
  smg_decode_module u_dec (
    .i_seg    (r_lat_seg),
    .o_valid  (w_dig_vld),
    .o_nibble (w_dig_nib)
  );

  assign w_lat_dec  = scan_decode(r_lat_scan);
  assign w_cap_idx  = w_lat_dec[1:0];
  assign w_cap_bit  = 4'b0001 << w_cap_idx;
  // Registered seen means completion is always the cycle after the last capture
  assign w_complete = (r_seen == 4'b1111);
  assign w_tmo_hit  = !w_cap && (r_tmo_cnt == TIMEOUT_CYC - 24'd1);

  // Frame assembly: slots, seen mask and sticky error; a repeated digit restarts the frame
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_slot <= '0;
      r_seen <= '0;
      r_err  <= 1'b0;
    end else if (w_cap) begin
      r_slot[w_cap_idx] <= w_dig_nib;
      if (r_seen[w_cap_idx]) begin
        r_seen <= w_cap_bit;
        r_err  <= !w_dig_vld;
      end else begin
        r_seen <= r_seen | w_cap_bit;
        r_err  <= r_err | !w_dig_vld;
      end
    end else if (w_complete || w_tmo_hit) begin
      r_seen <= '0;
      r_err  <= 1'b0;
    end
  end

  // Frame outputs: publish clean frames, flag bad ones, hold last good value
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Number_Sig   <= '0;
      Number_Valid <= 1'b0;
      Frame_Err    <= 1'b0;
    end else begin
      Number_Valid <= w_complete && !r_err;
      Frame_Err    <= w_complete && r_err;
      if (w_complete && !r_err) Number_Sig <= r_slot;
    end
  end

  // Scan watchdog: saturating count since last capture drives Scan_Lost
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tmo_cnt <= '0;
      Scan_Lost <= 1'b0;
    end else if (w_cap) begin
      r_tmo_cnt <= '0;
      Scan_Lost <= 1'b0;
    end else if (r_tmo_cnt != TIMEOUT_CYC) begin
      r_tmo_cnt <= r_tmo_cnt + 24'd1;
      if (w_tmo_hit) Scan_Lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_smg_capture_module.sv
// Directed bench for smg_capture_module with a short settle window and timeout.
module tb_smg_capture_module;

  localparam logic [15:0] SETTLE  = 16'd8;
  localparam logic [23:0] TIMEOUT = 24'd200;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [6:0]  SMG_Data = 7'h7F;
  logic [3:0]  Scan_Sig = 4'hF;
  logic [15:0] Number_Sig;
  logic        Number_Valid, Frame_Err, Scan_Lost;

  int n_assert = 0;
  int n_fail   = 0;
  int nv_cnt   = 0;
  int fe_cnt   = 0;
  int bad_pair = 0;
  logic nv_q = 1'b0, fe_q = 1'b0;

  smg_capture_module #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SMG_Data     (SMG_Data),
    .Scan_Sig     (Scan_Sig),
    .Number_Sig   (Number_Sig),
    .Number_Valid (Number_Valid),
    .Frame_Err    (Frame_Err),
    .Scan_Lost    (Scan_Lost)
  );

  always #5 CLK = ~CLK;

  // Pulse counters plus detection of back-to-back or coincident pulses
  always @(negedge CLK) begin
    if (Number_Valid) nv_cnt++;
    if (Frame_Err) fe_cnt++;
    if ((Number_Valid && Frame_Err) || (Number_Valid && nv_q) || (Frame_Err && fe_q)) bad_pair++;
    nv_q = Number_Valid;
    fe_q = Frame_Err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-copied active-low segment table
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: seg_of = 7'b1000000; 4'h1: seg_of = 7'b1111001;
      4'h2: seg_of = 7'b0100100; 4'h3: seg_of = 7'b0110000;
      4'h4: seg_of = 7'b0011001; 4'h5: seg_of = 7'b0010010;
      4'h6: seg_of = 7'b0000010; 4'h7: seg_of = 7'b1111000;
      4'h8: seg_of = 7'b0000000; 4'h9: seg_of = 7'b0010000;
      4'hA: seg_of = 7'b0001000; 4'hB: seg_of = 7'b0000011;
      4'hC: seg_of = 7'b1000110; 4'hD: seg_of = 7'b0100001;
      4'hE: seg_of = 7'b0000110; default: seg_of = 7'b0001110;
    endcase
  endfunction

  function automatic logic [3:0] scan_of(input int k);
    case (k)
      0: scan_of = 4'b1110;
      1: scan_of = 4'b1101;
      2: scan_of = 4'b1011;
      default: scan_of = 4'b0111;
    endcase
  endfunction

  task automatic digit(input int k, input logic [6:0] seg, input int n);
    Scan_Sig = scan_of(k);
    SMG_Data = seg;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic frame(input logic [15:0] v);
    digit(0, seg_of(v[3:0]), 50);
    digit(1, seg_of(v[7:4]), 50);
    digit(2, seg_of(v[11:8]), 50);
    digit(3, seg_of(v[15:12]), 50);
  endtask

  int nv0, fe0, lat;

  initial begin
    // Reset state
    #2;
    check("rst_num", 32'(Number_Sig), 32'h0000);
    check("rst_nv", 32'(Number_Valid), 32'h0);
    check("rst_fe", 32'(Frame_Err), 32'h0);
    check("rst_lost", 32'(Scan_Lost), 32'h0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Clean frame 7,b,0,E
    nv0 = nv_cnt; fe0 = fe_cnt;
    frame(16'hE0B7);
    check("t2_num", 32'(Number_Sig), 32'hE0B7);
    check("t2_nv", 32'(nv_cnt - nv0), 32'd1);
    check("t2_fe", 32'(fe_cnt - fe0), 32'd0);

    // Blank digit2 -> frame error, value held; then clean frame
    nv0 = nv_cnt; fe0 = fe_cnt;
    digit(0, seg_of(4'h1), 50);
    digit(1, seg_of(4'h2), 50);
    digit(2, 7'b1111111, 50);
    digit(3, seg_of(4'h3), 50);
    check("t3_fe", 32'(fe_cnt - fe0), 32'd1);
    check("t3_nv", 32'(nv_cnt - nv0), 32'd0);
    check("t3_hold", 32'(Number_Sig), 32'hE0B7);
    nv0 = nv_cnt; fe0 = fe_cnt;
    frame(16'h4321);
    check("t3_num", 32'(Number_Sig), 32'h4321);
    check("t3_nv2", 32'(nv_cnt - nv0), 32'd1);
    check("t3_fe2", 32'(fe_cnt - fe0), 32'd0);

    // Glitching digit1 never captures; capture 2+8+1 after it stops, pulse one later
    nv0 = nv_cnt; fe0 = fe_cnt;
    digit(0, seg_of(4'h5), 50);
    digit(2, seg_of(4'h7), 50);
    digit(3, seg_of(4'h9), 50);
    Scan_Sig = scan_of(1);
    for (int c = 0; c < 25; c++) begin
      SMG_Data = seg_of(4'h6);
      repeat (3) @(posedge CLK);
      #1 SMG_Data = seg_of(4'h8);
      @(posedge CLK);
      #1;
    end
    check("t4_nocap_nv", 32'(nv_cnt - nv0), 32'd0);
    check("t4_nocap_fe", 32'(fe_cnt - fe0), 32'd0);
    SMG_Data = seg_of(4'h6);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (Number_Valid) begin
        lat = i;
        break;
      end
    end
    check("t4_latency", 32'(lat), 32'd12);
    check("t4_num", 32'(Number_Sig), 32'h9765);

    // Scan stops: Scan_Lost exactly TIMEOUT cycles after the last capture
    Scan_Sig = 4'hF;
    SMG_Data = 7'h7F;
    repeat (198) @(posedge CLK);
    @(negedge CLK);
    check("t5_lost_early", 32'(Scan_Lost), 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    check("t5_lost", 32'(Scan_Lost), 32'h1);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    check("t5_lost_hold", 32'(Scan_Lost), 32'h1);
    check("t5_num_hold", 32'(Number_Sig), 32'h9765);
    nv0 = nv_cnt;
    digit(0, seg_of(4'hF), 50);
    check("t5_lost_clr", 32'(Scan_Lost), 32'h0);
    digit(1, seg_of(4'h2), 50);
    digit(2, seg_of(4'hA), 50);
    digit(3, seg_of(4'h1), 50);
    check("t5_num", 32'(Number_Sig), 32'h1A2F);
    check("t5_nv", 32'(nv_cnt - nv0), 32'd1);

    // Reset after two digits discards the partial frame
    digit(0, seg_of(4'h3), 50);
    digit(1, seg_of(4'h4), 50);
    RST = 1'b1;
    Scan_Sig = 4'hF;
    SMG_Data = 7'h7F;
    #2;
    check("t6_rst_num", 32'(Number_Sig), 32'h0000);
    check("t6_rst_lost", 32'(Scan_Lost), 32'h0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    nv0 = nv_cnt; fe0 = fe_cnt;
    digit(2, seg_of(4'h5), 50);
    digit(3, seg_of(4'h6), 50);
    check("t6_nv", 32'(nv_cnt - nv0), 32'd0);
    check("t6_fe", 32'(fe_cnt - fe0), 32'd0);
    check("t6_num", 32'(Number_Sig), 32'h0000);

    check("pulse_excl", 32'(bad_pair), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
